// File: rtl/nm_ctrl_gen.sv
// nm_ctrl_gen -- Nelder-Mead sequencing controller.
//
// Decides the order of simplex operations for an external datapath. The
// datapath does all vertex arithmetic, sorting and centroid work, keyed on
// state_o and vertex_o. Evaluations use a req/ack handshake.
//
// Optional feature: define NM_TOL_STOP_EN to stop at CHECK when
// (worst - best) <= tolerance. Without it, tol_i is ignored and
// converged_o stays 0.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start_i         begin a run (honoured in IDLE only)
//   max_iters_i     iteration limit, latched on accepted start
//   tol_i           convergence tolerance, latched on accepted start
//   eval_req_o      evaluation request (decoded from state)
//   eval_ack_i      evaluation complete, eval_fx_i valid
//   eval_fx_i       evaluated objective value
//   best/sec/worst_fx_i  sorted simplex values from the datapath
//   state_o         current state code
//   vertex_o        vertex index in INIT_EVAL / SHRINK_EVAL, else 0
//   iter_cnt_o      completed iterations (saturating)
//   busy_o          high outside IDLE
//   done_o          one-cycle pulse at end of run
//   converged_o     run ended on tolerance; held until next start
module nm_ctrl_gen #(
  parameter int NDIM = 3,
  parameter int FXW  = 25,
  parameter int ITW  = 8,
  parameter int VW   = $clog2(NDIM + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [ITW-1:0] max_iters_i,
  input  logic [FXW-1:0] tol_i,
  output logic           eval_req_o,
  input  logic           eval_ack_i,
  input  logic [FXW-1:0] eval_fx_i,
  input  logic [FXW-1:0] best_fx_i,
  input  logic [FXW-1:0] sec_fx_i,
  input  logic [FXW-1:0] worst_fx_i,
  output logic [3:0]     state_o,
  output logic [VW-1:0]  vertex_o,
  output logic [ITW-1:0] iter_cnt_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           converged_o
);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    INIT_EVAL   = 4'd1,
    SORT        = 4'd2,
    CHECK       = 4'd3,
    CENTROID    = 4'd4,
    REFLECT     = 4'd5,
    EXPAND      = 4'd6,
    ACC_R       = 4'd7,
    ACC_E       = 4'd8,
    CONTR_OUT   = 4'd9,
    CONTR_IN    = 4'd10,
    ACC_C       = 4'd11,
    SHRINK      = 4'd12,
    SHRINK_EVAL = 4'd13,
    ITER_END    = 4'd14,
    DONE        = 4'd15
  } state_e;

  localparam logic [VW-1:0]  LAST_V  = VW'(NDIM);
  localparam logic [ITW-1:0] ITER_MAX = {ITW{1'b1}};

  state_e         state_q, state_d;
  logic [VW-1:0]  vertex_q, vertex_d;
  logic [ITW-1:0] iter_q, iter_d;
  logic [ITW-1:0] max_iters_q, max_iters_d;
  logic [FXW-1:0] r_fx_q, r_fx_d;
  logic           converged_q, converged_d;
  logic           tol_hit_s;

`ifdef NM_TOL_STOP_EN
  logic [FXW-1:0] tol_q;

  // Tolerance latched on accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tol_q <= {FXW{1'b0}};
    end else if (state_q == IDLE && start_i) begin
      tol_q <= tol_i;
    end
  end

  // worst >= best after sorting, so the unsigned difference cannot wrap.
  assign tol_hit_s = ((worst_fx_i - best_fx_i) <= tol_q);
`else
  logic unused_tol_s;
  assign unused_tol_s = ^tol_i;
  assign tol_hit_s    = 1'b0;
`endif

  // State and datapath-control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vertex_q    <= {VW{1'b0}};
      iter_q      <= {ITW{1'b0}};
      max_iters_q <= {ITW{1'b0}};
      r_fx_q      <= {FXW{1'b0}};
      converged_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vertex_q    <= vertex_d;
      iter_q      <= iter_d;
      max_iters_q <= max_iters_d;
      r_fx_q      <= r_fx_d;
      converged_q <= converged_d;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d     = state_q;
    vertex_d    = vertex_q;
    iter_d      = iter_q;
    max_iters_d = max_iters_q;
    r_fx_d      = r_fx_q;
    converged_d = converged_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = INIT_EVAL;
          vertex_d    = {VW{1'b0}};
          iter_d      = {ITW{1'b0}};
          max_iters_d = max_iters_i;
          converged_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      INIT_EVAL, SHRINK_EVAL: begin
        if (eval_ack_i) begin
          if (vertex_q == LAST_V) begin
            state_d  = (state_q == INIT_EVAL) ? SORT : ITER_END;
            vertex_d = {VW{1'b0}};
          end else begin
            vertex_d = vertex_q + {{(VW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = state_q;
        end
      end
      SORT:     state_d = CHECK;
      CHECK: begin
        if (iter_q == max_iters_q) begin
          state_d = DONE;
        end else if (tol_hit_s) begin
          state_d     = DONE;
          converged_d = 1'b1;
        end else begin
          state_d = CENTROID;
        end
      end
      CENTROID: state_d = REFLECT;
      REFLECT: begin
        if (eval_ack_i) begin
          r_fx_d = eval_fx_i;
          if (eval_fx_i < best_fx_i) begin
            state_d = EXPAND;
          end else if (eval_fx_i < sec_fx_i) begin
            state_d = ACC_R;
          end else if (eval_fx_i < worst_fx_i) begin
            state_d = CONTR_OUT;
          end else begin
            state_d = CONTR_IN;
          end
        end else begin
          state_d = REFLECT;
        end
      end
      EXPAND: begin
        if (eval_ack_i) begin
          state_d = (eval_fx_i < r_fx_q) ? ACC_E : ACC_R;
        end else begin
          state_d = EXPAND;
        end
      end
      CONTR_OUT: begin
        if (eval_ack_i) begin
          state_d = (eval_fx_i <= r_fx_q) ? ACC_C : SHRINK;
        end else begin
          state_d = CONTR_OUT;
        end
      end
      CONTR_IN: begin
        if (eval_ack_i) begin
          state_d = (eval_fx_i <= worst_fx_i) ? ACC_C : SHRINK;
        end else begin
          state_d = CONTR_IN;
        end
      end
      ACC_R, ACC_E, ACC_C: state_d = ITER_END;
      SHRINK: begin
        // Vertex 0 is the best point and is kept; shrink re-evaluates 1..NDIM.
        state_d  = SHRINK_EVAL;
        vertex_d = {{(VW-1){1'b0}}, 1'b1};
      end
      ITER_END: begin
        state_d = SORT;
        if (iter_q != ITER_MAX) begin
          iter_d = iter_q + {{(ITW-1){1'b0}}, 1'b1};
        end else begin
          iter_d = iter_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign eval_req_o  = (state_q == INIT_EVAL) || (state_q == REFLECT) ||
                       (state_q == EXPAND)    || (state_q == CONTR_OUT) ||
                       (state_q == CONTR_IN)  || (state_q == SHRINK_EVAL);
  assign vertex_o    = ((state_q == INIT_EVAL) || (state_q == SHRINK_EVAL)) ?
                       vertex_q : {VW{1'b0}};
  assign state_o     = state_q;
  assign iter_cnt_o  = iter_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign converged_o = converged_q;

endmodule

// File: tb/tb_nm_ctrl_gen.sv
module tb_nm_ctrl_gen;
  localparam int NDIM = 3;
  localparam int FXW  = 25;
  localparam int ITW  = 8;
  localparam int VW   = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_i;
  logic [ITW-1:0] max_iters_i;
  logic [FXW-1:0] tol_i;
  logic           eval_req_o;
  logic           eval_ack_i;
  logic [FXW-1:0] eval_fx_i;
  logic [FXW-1:0] best_fx_i, sec_fx_i, worst_fx_i;
  logic [3:0]     state_o;
  logic [VW-1:0]  vertex_o;
  logic [ITW-1:0] iter_cnt_o;
  logic           busy_o, done_o, converged_o;

  nm_ctrl_gen #(.NDIM(NDIM), .FXW(FXW), .ITW(ITW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .max_iters_i(max_iters_i),
    .tol_i(tol_i), .eval_req_o(eval_req_o), .eval_ack_i(eval_ack_i),
    .eval_fx_i(eval_fx_i), .best_fx_i(best_fx_i), .sec_fx_i(sec_fx_i),
    .worst_fx_i(worst_fx_i), .state_o(state_o), .vertex_o(vertex_o),
    .iter_cnt_o(iter_cnt_o), .busy_o(busy_o), .done_o(done_o),
    .converged_o(converged_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Scoreboard queues: eval events (state*16+vertex), state-change trace,
  // done records (iter*2+converged). fx_src is the objective value stream.
  int exp_ev[$];
  int exp_tr[$];
  int exp_done[$];
  int fx_src[$];
  int drv_k;
  int dly;
  bit drv_en = 1'b0;
  bit mon_en = 1'b0;
  int done_seen = 0;
  int last_conv;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Reference model: walks the Nelder-Mead decision rules over the fx stream.
  task automatic build_model(input int b, input int s, input int w,
                             input int t, input int m);
    int it = 0;
    int k = 0;
    int r, e;
    bit conv, shrink;
    exp_tr.push_back(1);
    for (int v = 0; v <= NDIM; v++) begin
      exp_ev.push_back(16 + v);
      k++;
    end
    forever begin
      exp_tr.push_back(2);
      exp_tr.push_back(3);
      conv = 1'b0;
`ifdef NM_TOL_STOP_EN
      conv = ((w - b) <= t);
`endif
      if (it == m || conv) begin
        last_conv = (it == m) ? 0 : 1;
        exp_tr.push_back(15);
        exp_tr.push_back(0);
        exp_done.push_back(it * 2 + last_conv);
        break;
      end
      exp_tr.push_back(4);
      exp_tr.push_back(5);
      exp_ev.push_back(5 * 16);
      r = fx_src[k]; k++;
      if (r < b) begin
        exp_tr.push_back(6);
        exp_ev.push_back(6 * 16);
        e = fx_src[k]; k++;
        exp_tr.push_back((e < r) ? 8 : 7);
      end else if (r < s) begin
        exp_tr.push_back(7);
      end else begin
        if (r < w) begin
          exp_tr.push_back(9);
          exp_ev.push_back(9 * 16);
          e = fx_src[k]; k++;
          shrink = !(e <= r);
        end else begin
          exp_tr.push_back(10);
          exp_ev.push_back(10 * 16);
          e = fx_src[k]; k++;
          shrink = !(e <= w);
        end
        if (shrink) begin
          exp_tr.push_back(12);
          exp_tr.push_back(13);
          for (int v = 1; v <= NDIM; v++) begin
            exp_ev.push_back(13 * 16 + v);
            k++;
          end
        end else begin
          exp_tr.push_back(11);
        end
      end
      exp_tr.push_back(14);
      it = (it == 255) ? 255 : it + 1;
    end
  endtask

  // Evaluator: acks each request after a random 0..2 cycle delay.
  initial begin
    eval_ack_i = 1'b0;
    eval_fx_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (drv_en) begin
        if (eval_req_o && dly == 0 && drv_k < fx_src.size()) begin
          eval_ack_i = 1'b1;
          eval_fx_i  = FXW'(fx_src[drv_k]);
          drv_k++;
          dly = $urandom_range(0, 2);
        end else begin
          eval_ack_i = 1'b0;
          if (eval_req_o && dly > 0) dly--;
        end
      end
    end
  end

  // Monitor: compares observed handshakes, state changes and done pulses.
  initial begin
    int prev_st = 0;
    bit prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (eval_req_o && eval_ack_i) begin
          if (exp_ev.size() > 0) chk("eval_event", state_o * 16 + vertex_o, exp_ev.pop_front());
          else chk("eval_event_extra", state_o * 16 + vertex_o, -1);
        end
        if (state_o != prev_st) begin
          if (exp_tr.size() > 0) chk("state_trace", state_o, exp_tr.pop_front());
          else chk("state_trace_extra", state_o, -1);
          prev_st = state_o;
        end
        if (done_o) begin
          if (exp_done.size() > 0) chk("done_iter_conv", iter_cnt_o * 2 + converged_o, exp_done.pop_front());
          else chk("done_extra", 1, 0);
          chk("done_single_pulse", prev_done, 0);
          done_seen++;
        end
        prev_done = done_o;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, s, w, t, m, cyc, target;
    rst = 1'b1;
    start_i = 1'b0;
    max_iters_i = '0;
    tol_i = '0;
    best_fx_i = '0;
    sec_fx_i = '0;
    worst_fx_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_req", eval_req_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_iter", iter_cnt_o, 0);
    chk("rst_conv", converged_o, 0);
    chk("rst_busy", busy_o, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    drv_en = 1'b1;

    for (int run = 0; run < 40; run++) begin
      b = $urandom_range(50, 150);
      s = b + $urandom_range(0, 100);
      w = s + $urandom_range(0, 100);
      t = $urandom_range(0, 150);
      m = (run == 0) ? 0 : (run == 1) ? 2 : $urandom_range(0, 6);
      fx_src.delete();
      for (int i = 0; i < 64; i++) begin
        case ($urandom_range(0, 7))
          0: fx_src.push_back(b - 1);
          1: fx_src.push_back(b);
          2: fx_src.push_back(s - 1);
          3: fx_src.push_back(s);
          4: fx_src.push_back(w);
          5: fx_src.push_back(w + 1);
          default: fx_src.push_back($urandom_range(0, 400));
        endcase
      end
      build_model(b, s, w, t, m);
      drv_k = 0;
      dly = $urandom_range(0, 2);
      best_fx_i = FXW'(b);
      sec_fx_i = FXW'(s);
      worst_fx_i = FXW'(w);
      tol_i = FXW'(t);
      max_iters_i = ITW'(m);
      target = done_seen + 1;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      // start and new limits while busy must be ignored
      repeat (3) @(posedge clk);
      #1;
      start_i = 1'b1;
      max_iters_i = ITW'(m + 3);
      tol_i = '0;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      cyc = 0;
      while (done_seen < target && cyc < 3000) begin
        @(posedge clk);
        cyc++;
      end
      chk("run_finished", (done_seen >= target) ? 1 : 0, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("ev_queue_drained", exp_ev.size(), 0);
      chk("trace_queue_drained", exp_tr.size(), 0);
      chk("conv_held", converged_o, last_conv);
      exp_ev.delete();
      exp_tr.delete();
      exp_done.delete();
    end

    // Reset in the middle of EXPAND with a request outstanding.
    mon_en = 1'b0;
    drv_en = 1'b0;
    @(posedge clk);
    #1;
    eval_ack_i = 1'b0;
    eval_fx_i = FXW'(5);
    best_fx_i = FXW'(10);
    sec_fx_i = FXW'(20);
    worst_fx_i = FXW'(30);
    max_iters_i = ITW'(5);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    cyc = 0;
    while (state_o != 4'd6 && cyc < 100) begin
      eval_ack_i = eval_req_o;
      @(posedge clk);
      #1;
      cyc++;
    end
    eval_ack_i = 1'b0;
    chk("reached_expand", state_o, 6);
    chk("expand_req", eval_req_o, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_state", state_o, 0);
    chk("midrst_req", eval_req_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_vertex", vertex_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    eval_ack_i = 1'b1;
    @(posedge clk);
    #1;
    chk("late_ack_ignored", state_o, 0);
    chk("late_ack_iter", iter_cnt_o, 0);
    eval_ack_i = 1'b0;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("restart_state", state_o, 1);
    chk("restart_vertex", vertex_o, 0);
    chk("restart_req", eval_req_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/nm_ctrl_gen.md
Name: nm_ctrl_gen

Overview:
- Parametrised next-generation Nelder-Mead sequencing controller for the optimiser datapath.
- Handles any dimension count NDIM, so the simplex has NDIM+1 vertices.
- Uses a req/ack evaluator handshake in place of a level busy input.
- Takes a run-time iteration limit, supports an optional tolerance-based stop, and issues a single done pulse.
- The datapath performs all vertex arithmetic, sorting and centroid updates, keyed on state_o/vertex_o. This block decides sequencing only.

Parameters:
- NDIM, 3, problem dimension; the simplex has NDIM+1 vertices.
- FXW, 25, objective value width, unsigned (3Qp, p=22).
- ITW, 8, iteration counter width.
- VW, $clog2(NDIM+1), vertex index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- start_i  in  1  begin an optimisation run; honoured in IDLE only.
- max_iters_i  in  ITW  iteration limit; sampled on accepted start.
- tol_i  in  FXW  convergence tolerance; sampled on accepted start.
- eval_req_o  out  1  objective evaluation request.
- eval_ack_i  in  1  evaluation complete; eval_fx_i valid this cycle.
- eval_fx_i  in  FXW  evaluated objective value.
- best_fx_i / sec_fx_i / worst_fx_i  in  FXW each  sorted simplex values p0, p(NDIM-1) and p(NDIM) from the datapath.
- state_o  out  4  current state code.
- vertex_o  out  VW  vertex index during INIT_EVAL and SHRINK_EVAL; 0 otherwise.
- iter_cnt_o  out  ITW  completed iterations.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse at end of run.
- converged_o  out  1  run ended on tolerance; held until next accepted start.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - iter_cnt_o, vertex_o, eval_req_o, done_o and converged_o go to 0.
  - An in-flight evaluation is abandoned; a late eval_ack_i in IDLE is ignored.
- State codes: IDLE=0, INIT_EVAL=1, SORT=2, CHECK=3, CENTROID=4, REFLECT=5, EXPAND=6, ACC_R=7, ACC_E=8, CONTR_OUT=9, CONTR_IN=10, ACC_C=11, SHRINK=12, SHRINK_EVAL=13, ITER_END=14, DONE=15.
- Evaluation states (INIT_EVAL, REFLECT, EXPAND, CONTR_OUT, CONTR_IN, SHRINK_EVAL):
  - eval_req_o is high throughout and combinational from state.
  - The state holds until eval_ack_i.
  - An ack outside these states is ignored.
  - An ack in the first cycle of a state is legal.
- IDLE:
  - start_i moves to INIT_EVAL with vertex_o=0 and iter_cnt cleared.
  - max_iters and tol are latched; converged_o is cleared.
- INIT_EVAL: each ack increments vertex_o. An ack at vertex NDIM moves to SORT.
- SORT and CENTROID: one cycle each. The datapath acts on them.
- SORT always goes to CHECK.
- CHECK, in priority order:
  - If iter_cnt == max_iters, go to DONE.
  - Else if the tolerance condition holds (optional feature), set converged_o and go to DONE.
  - Else go to CENTROID.
- CENTROID goes to REFLECT.
- REFLECT: on ack, r_fx is latched from eval_fx_i.
  - eval_fx_i < best_fx_i: go to EXPAND.
  - else < sec_fx_i: go to ACC_R.
  - else < worst_fx_i: go to CONTR_OUT.
  - else: go to CONTR_IN.
- EXPAND: on ack, eval_fx_i < r_fx goes to ACC_E, else ACC_R.
- CONTR_OUT: on ack, eval_fx_i <= r_fx goes to ACC_C, else SHRINK.
- CONTR_IN: on ack, eval_fx_i <= worst_fx_i goes to ACC_C, else SHRINK.
- ACC_R, ACC_E and ACC_C: one cycle, then ITER_END.
- SHRINK: one cycle, then SHRINK_EVAL with vertex_o=1.
- SHRINK_EVAL: increments vertex_o per ack, as in INIT_EVAL. An ack at vertex NDIM goes to ITER_END.
- ITER_END: iter_cnt increments, saturating at 2^ITW-1; then SORT.
- DONE: done_o=1 for this single cycle; then IDLE.
- Comparisons are all unsigned, FXW wide.
- max_iters_i=0: the run is initial evals, SORT, CHECK, then DONE, with iter_cnt 0.

Optional Feature:
- Macro NM_TOL_STOP_EN.
- Defined: CHECK also terminates when (worst_fx_i - best_fx_i) <= tol_q. The subtraction is unsigned, and worst >= best is guaranteed post-sort. converged_o is set. The iteration limit keeps priority.
- Undefined: tol_i is ignored and converged_o is tied 0.

Test Plan:
- NDIM=3, max_iters=2, ack 1 cycle after each req, REFLECT evals always below best, EXPAND eval below r -> states 1,2,3,4,5,6,8,14,2,3,… ; done_o single pulse; iter_cnt_o=2; 4 INIT_EVAL reqs with vertex_o 0..3.
- best=10, sec=20, worst=30, reflect fx=25, contract fx=40 -> CONTR_OUT then SHRINK; SHRINK_EVAL issues 3 reqs with vertex_o=1,2,3; then ITER_END.
- reflect fx=30 (equals worst) -> CONTR_IN; contract fx=30 -> ACC_C (<= boundary).
- NM_TOL_STOP_EN, tol=5, best=100, worst=104 after init sort -> DONE from first CHECK; converged_o=1; iter_cnt_o=0. Repeat with macro undefined -> runs to max_iters, converged_o=0.
- rst asserted mid-EXPAND with eval_req_o high -> same cycle: state_o=0, eval_req_o=0; late eval_ack_i ignored; start_i next runs from vertex 0.
- max_iters_i=0 -> done after 4 evals plus SORT/CHECK; start_i pulsed while busy -> ignored.
